// File: rtl/decoder_seq.sv
// -----------------------------------------------------------------------------
// decoder_seq : sequential 3-to-8 (CODE_W-to-2**CODE_W) binary decoder.
//
// Accepts a binary code over a valid/ready handshake and drives the matching
// one-hot output, registered, for HOLD cycles.
// Back-to-back codes are taken with no idle gap between them.
//
// Optional feature (macro DECODER_SEQ_CNT_EN):
//   adds output dec_cnt, a free-running count of accepted codes that wraps
//   at 2**CNT_W and is cleared only by rst.
// -----------------------------------------------------------------------------
module decoder_seq #(
  parameter int CODE_W = 3,
  parameter int HOLD   = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CODE_W-1:0]        i,
  output logic [(2**CODE_W)-1:0]   o,
  output logic                     o_valid,
`ifdef DECODER_SEQ_CNT_EN
  output logic [CNT_W-1:0]         dec_cnt,
`endif
  output logic                     busy
);

  localparam int OUT_W  = 2**CODE_W;
  // HOLD is limited to 1..255, so an 8-bit down-counter always suffices.
  localparam int HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t              state_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [OUT_W-1:0]    o_q;
  logic                o_valid_q;
  logic                busy_q;
  logic                accept_d;
  logic [OUT_W-1:0]    onehot_d;

  // Binary code to one-hot; every code value maps to exactly one bit.
  function automatic logic [OUT_W-1:0] decode(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] one;
    one    = {{(OUT_W-1){1'b0}}, 1'b1};
    decode = one << code;
  endfunction

  // Ready in IDLE, or in HOLD once the last hold cycle is reached; never under reset.
  assign in_ready = en && !rst &&
                    ((state_q == ST_IDLE) || (hold_cnt_q == {HOLD_W{1'b0}}));
  assign accept_d = in_valid && in_ready;
  assign onehot_d = decode(i);

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign busy    = busy_q;

  // Decode FSM: state, hold counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= {HOLD_W{1'b0}};
      o_q        <= {OUT_W{1'b0}};
      o_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else if (!en) begin
      // Disable aborts any hold in progress; it is not resumed later.
      state_q    <= ST_IDLE;
      hold_cnt_q <= {HOLD_W{1'b0}};
      o_q        <= {OUT_W{1'b0}};
      o_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= HOLD_RELOAD;
            o_q        <= onehot_d;
            o_valid_q  <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= {HOLD_W{1'b0}};
            o_q        <= {OUT_W{1'b0}};
            o_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q != {HOLD_W{1'b0}}) begin
            hold_cnt_q <= hold_cnt_q - 8'd1;
          end else if (accept_d) begin
            // Chain straight into the next code with no zero cycle.
            hold_cnt_q <= HOLD_RELOAD;
            o_q        <= onehot_d;
            o_valid_q  <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
            o_q        <= {OUT_W{1'b0}};
            o_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          hold_cnt_q <= {HOLD_W{1'b0}};
          o_q        <= {OUT_W{1'b0}};
          o_valid_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef DECODER_SEQ_CNT_EN
  logic [CNT_W-1:0] dec_cnt_q;

  assign dec_cnt = dec_cnt_q;

  // Accept counter: wraps naturally, unaffected by en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt_q <= {CNT_W{1'b0}};
    end else if (accept_d) begin
      dec_cnt_q <= dec_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      dec_cnt_q <= dec_cnt_q;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// -----------------------------------------------------------------------------
// tb_decoder_seq : directed, table-driven bench for decoder_seq.
// Instance u_h4 uses HOLD=4, instance u_h1 uses HOLD=1.
// Build with +define+DECODER_SEQ_CNT_EN to also exercise dec_cnt.
// -----------------------------------------------------------------------------
module tb_decoder_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en_a, v_a, rdy_a, ov_a, busy_a;
  logic [2:0] i_a;
  logic [7:0] o_a;
  logic       en_b, v_b, rdy_b, ov_b, busy_b;
  logic [2:0] i_b;
  logic [7:0] o_b;
`ifdef DECODER_SEQ_CNT_EN
  logic [7:0] cnt_a, cnt_b;
`endif

  decoder_seq #(.CODE_W(3), .HOLD(4), .CNT_W(8)) u_h4 (
    .clk(clk), .rst(rst), .en(en_a), .in_valid(v_a), .in_ready(rdy_a),
    .i(i_a), .o(o_a), .o_valid(ov_a),
`ifdef DECODER_SEQ_CNT_EN
    .dec_cnt(cnt_a),
`endif
    .busy(busy_a)
  );

  decoder_seq #(.CODE_W(3), .HOLD(1), .CNT_W(8)) u_h1 (
    .clk(clk), .rst(rst), .en(en_b), .in_valid(v_b), .in_ready(rdy_b),
    .i(i_b), .o(o_b), .o_valid(ov_b),
`ifdef DECODER_SEQ_CNT_EN
    .dec_cnt(cnt_b),
`endif
    .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic       v;
    logic [2:0] i;
    logic       rdy;   // in_ready expected before the edge
    logic [7:0] o;     // expected after the edge
    logic       ov;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic v, input logic [2:0] i, input logic rdy,
                     input logic [7:0] o, input logic ov, input logic busy);
    vec_t t;
    t.en = en; t.v = v; t.i = i; t.rdy = rdy; t.o = o; t.ov = ov; t.busy = busy;
    tbl.push_back(t);
  endtask

  // One cycle on the HOLD=4 instance.
  task automatic step_a(input vec_t t, input int idx);
    @(negedge clk);
    en_a = t.en; v_a = t.v; i_a = t.i;
    #1;
    chk($sformatf("h4[%0d] in_ready", idx), {31'd0, rdy_a}, {31'd0, t.rdy});
    @(posedge clk);
    #1;
    chk($sformatf("h4[%0d] o", idx), {24'd0, o_a}, {24'd0, t.o});
    chk($sformatf("h4[%0d] o_valid", idx), {31'd0, ov_a}, {31'd0, t.ov});
    chk($sformatf("h4[%0d] busy", idx), {31'd0, busy_a}, {31'd0, t.busy});
    chk($sformatf("h4[%0d] onehot0", idx), {31'd0, $onehot0(o_a)}, 32'd1);
  endtask

  // One cycle on the HOLD=1 instance.
  task automatic step_b(input logic en, input logic v, input logic [2:0] i,
                        input logic rdy, input logic [7:0] o, input string tag);
    @(negedge clk);
    en_b = en; v_b = v; i_b = i;
    #1;
    chk({tag, " in_ready"}, {31'd0, rdy_b}, {31'd0, rdy});
    @(posedge clk);
    #1;
    chk({tag, " o"}, {24'd0, o_b}, {24'd0, o});
  endtask

  initial begin
    logic [7:0] exp_oh;

    // Scenario 1: single code 5, HOLD=4 (entries 0..4)
    add(1'b1, 1'b1, 3'd5, 1'b1, 8'h20, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b0, 8'h20, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0);
    // Scenario 2: codes 0 then 7 back-to-back, i changes while not ready
    add(1'b1, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1, 1'b1);
    add(1'b1, 1'b1, 3'd7, 1'b0, 8'h01, 1'b1, 1'b1);
    add(1'b1, 1'b1, 3'd7, 1'b0, 8'h01, 1'b1, 1'b1);
    add(1'b1, 1'b1, 3'd7, 1'b0, 8'h01, 1'b1, 1'b1);
    add(1'b1, 1'b1, 3'd7, 1'b1, 8'h80, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b0, 8'h80, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b0, 8'h80, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b0, 8'h80, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0);
    // Scenario 4: code 3, en dropped mid-hold, pending code 6 held upstream
    add(1'b1, 1'b1, 3'd3, 1'b1, 8'h08, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 1'b1);
    add(1'b0, 1'b1, 3'd6, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd6, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 1'b1, 3'd6, 1'b1, 8'h40, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b0, 8'h40, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b0, 8'h40, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b0, 8'h40, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Reset state
    rst = 1'b1;
    en_a = 1'b1; v_a = 1'b1; i_a = 3'd2;
    en_b = 1'b1; v_b = 1'b1; i_b = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("reset o", {24'd0, o_a}, 32'd0);
    chk("reset o_valid", {31'd0, ov_a}, 32'd0);
    chk("reset busy", {31'd0, busy_a}, 32'd0);
    chk("reset in_ready", {31'd0, rdy_a}, 32'd0);
    chk("reset h1 in_ready", {31'd0, rdy_b}, 32'd0);
`ifdef DECODER_SEQ_CNT_EN
    chk("reset dec_cnt", {24'd0, cnt_a}, 32'd0);
`endif
    @(negedge clk);
    en_a = 1'b0; v_a = 1'b0; en_b = 1'b0; v_b = 1'b0;
    rst = 1'b0;

    // Table-driven scenarios on HOLD=4
    for (int k = 0; k < tbl.size(); k++) begin
      step_a(tbl[k], k);
    end

    // HOLD=1 streaming: codes 0..7 one per cycle, in_ready stays high
    for (int k = 0; k < 8; k++) begin
      exp_oh = 8'd1 << k;
      step_b(1'b1, 1'b1, 3'(k), 1'b1, exp_oh, $sformatf("h1 stream[%0d]", k));
    end
    step_b(1'b1, 1'b0, 3'd0, 1'b1, 8'h00, "h1 drain");

    // Reset mid-hold with o=0x10: clears without a clock edge
    begin
      vec_t t;
      t.en = 1'b1; t.v = 1'b1; t.i = 3'd4; t.rdy = 1'b1; t.o = 8'h10; t.ov = 1'b1; t.busy = 1'b1;
      step_a(t, 100);
      t.v = 1'b0; t.i = 3'd0; t.rdy = 1'b0;
      step_a(t, 101);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async rst o", {24'd0, o_a}, 32'd0);
    chk("async rst o_valid", {31'd0, ov_a}, 32'd0);
    chk("async rst busy", {31'd0, busy_a}, 32'd0);
    chk("async rst in_ready", {31'd0, rdy_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // First accept after release behaves like scenario 1
    for (int k = 0; k < 5; k++) begin
      step_a(tbl[k], 200 + k);
    end

`ifdef DECODER_SEQ_CNT_EN
    // dec_cnt on HOLD=1: 257 accepts with an en-low gap, wraps to 1
    chk("cnt after rst", {24'd0, cnt_b}, 32'd0);
    for (int k = 0; k < 128; k++) begin
      exp_oh = 8'd1 << (k % 8);
      step_b(1'b1, 1'b1, 3'(k % 8), 1'b1, exp_oh, $sformatf("cnt1[%0d]", k));
    end
    step_b(1'b0, 1'b1, 3'd1, 1'b0, 8'h00, "cnt en low 0");
    step_b(1'b0, 1'b1, 3'd1, 1'b0, 8'h00, "cnt en low 1");
    chk("cnt kept over en low", {24'd0, cnt_b}, 32'd128);
    for (int k = 0; k < 129; k++) begin
      exp_oh = 8'd1 << (k % 8);
      step_b(1'b1, 1'b1, 3'(k % 8), 1'b1, exp_oh, $sformatf("cnt2[%0d]", k));
    end
    chk("cnt wrap", {24'd0, cnt_b}, 32'd1);
    step_b(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, "cnt en low 2");
    chk("cnt kept after en toggle", {24'd0, cnt_b}, 32'd1);
    chk("h4 cnt", {24'd0, cnt_a}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Sequential 3-to-8 binary decoder, the inverse of the team's one-hot-to-binary encoder.
- Accepts a binary code over a valid/ready handshake and drives the matching one-hot output, registered, for a programmable number of cycles.
- Used to fire one-hot select/strobe lines (mux selects, bank enables) from a binary command source.
- Supports back-to-back codes without gaps.

Parameters:
- CODE_W, 3, width of binary input code; output width is 2**CODE_W (derived, not overridable).
- HOLD, 4, cycles each one-hot output stays asserted; legal range 1..255.
- CNT_W, 8, width of the decode counter (optional feature only).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; low forces outputs to zero and blocks acceptance.
- in_valid  input  1  code on i is valid.
- in_ready  output  1  block can accept a code this cycle.
- i  input  CODE_W  binary code to decode.
- o  output  2**CODE_W  registered one-hot output.
- o_valid  output  1  o currently carries a decoded code.
- busy  output  1  high in HOLD state.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: o=0, o_valid=0, busy=0, state=IDLE, hold counter=0. in_ready is combinational and reads 0 while rst is high.
- Acceptance: occurs on a rising edge where in_valid && in_ready && en. i is sampled at that edge.

State machine (IDLE, HOLD):
- IDLE:
  - in_ready = en.
  - On accept: o <= 1 << i, o_valid <= 1, hold counter <= HOLD-1, state <= HOLD.
- HOLD:
  - busy = 1.
  - in_ready = en && (hold counter == 0).
  - If counter != 0: decrement; o is unchanged.
  - If counter == 0 and a new accept occurs: o <= 1 << new i, counter <= HOLD-1, stay in HOLD. There is no idle gap between codes.
  - If counter == 0 and no accept: o <= 0, o_valid <= 0, state <= IDLE.

Latency and timing:
- o is valid in the cycle following the accept edge.
- o stays asserted for exactly HOLD cycles per accepted code.
- Sustained throughput is one code per HOLD cycles. With HOLD=1, in_ready stays high while en=1, giving one code per cycle.

Boundary conditions:
- o is always zero or exactly one bit set; it is never multi-hot.
- Every CODE_W-bit value is a legal code, so no error case exists.
- en low:
  - in_ready=0 combinationally.
  - At the next edge: state <= IDLE, o <= 0, o_valid <= 0, counter <= 0.
  - An in-progress hold is aborted, not resumed.
  - A code presented while en is low is not consumed; upstream keeps it.
- en and in_valid both rising in the same cycle from IDLE: accepted at that edge.
- in_valid high while not ready: ignored; i may change freely.
- Reset asserted mid-hold: outputs clear immediately (asynchronously). Operation resumes in IDLE on the first edge after deassertion.

Optional Feature:
- Macro: DECODER_SEQ_CNT_EN.
- Defined:
  - Adds output port dec_cnt (output, CNT_W), reset to 0.
  - dec_cnt increments by 1 on every accept edge and wraps from 2**CNT_W-1 to 0.
  - dec_cnt is not cleared by en low.
- Undefined:
  - Port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, HOLD=4, en=1, single code i=5 accepted at edge k:
  - o=8'b0010_0000, o_valid=1 for cycles k+1..k+4.
  - in_ready=0 for the first 3 of those cycles and high in the 4th.
  - o=0 after the 4th cycle.
- HOLD=4, codes 0 then 7 with in_valid held high: o=8'b0000_0001 for 4 cycles, then 8'b1000_0000 for 4 cycles, with no zero cycle between.
- HOLD=1, codes 0..7 streamed one per cycle: in_ready constantly 1; o walks 0x01, 0x02 .. 0x80 on consecutive cycles.
- HOLD=4, i=3 accepted, en dropped 2 cycles later:
  - Next edge gives o=0, o_valid=0, state IDLE.
  - While en=0 with in_valid=1, in_ready=0 and no accept occurs.
  - Re-asserting en accepts the pending code.
- rst pulsed mid-hold with o=0x10: o clears without waiting for a clock edge; first accept after release behaves per scenario 1.
- DECODER_SEQ_CNT_EN defined, CNT_W=8, HOLD=1, 257 accepts: dec_cnt reads 1 after the final accept (wrap verified); en toggles do not clear it.
